// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for one 4-digit seven-segment display,
// with minimum hold time and active-low digit multiplexing.
module seg_display_arbiter #(
    parameter int SCAN_DVSR = 50000,
    parameter int HOLD_DVSR = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_en,
    input  logic [2:0]  req,
    input  logic [31:0] src0_seg,
    input  logic [31:0] src1_seg,
    input  logic [31:0] src2_seg,
    input  logic [3:0]  src0_dig_en,
    input  logic [3:0]  src1_dig_en,
    input  logic [3:0]  src2_dig_en,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);
    localparam int SW = $clog2(SCAN_DVSR);
    localparam int HW = $clog2(HOLD_DVSR);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     owner_q, owner_d;
    logic [1:0]     rr_last_q, rr_last_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]     dig_idx_q, dig_idx_d;
    logic [2:0]     grant_q, grant_d;
    logic           busy_q, busy_d;
    logic [3:0]     an_q, an_d;
    logic [7:0]     sseg_q, sseg_d;

    logic           pick_valid;
    logic [1:0]     pick_idx;
    logic [1:0]     base;
    logic [2:0]     sum;
    logic [1:0]     cand;
    logic           hold_done;
    logic           owner_req;
    logic           scan_tick;
    logic [31:0]    own_seg;
    logic [3:0]     own_en;
    logic           lit;

    // Descending search so the nearest candidate after base wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        sum        = 3'd0;
        cand       = 2'd0;
        base       = (state_q == OWN) ? owner_q : rr_last_q;
        for (int k = 3; k >= 1; k--) begin
            sum  = {1'b0, base} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (req[cand] && !(state_q == OWN && k == 3)) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_done = (hold_cnt_q == HW'(HOLD_DVSR - 1));
    assign owner_req = req[owner_q];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = OWN;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    hold_cnt_d = '0;
                    if (pick_valid) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d   = IDLE;
                        rr_last_d = owner_q;
                    end
                end else if (hold_done && pick_valid) begin
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end else if (!hold_done) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == OWN);
        grant_d = busy_d ? (3'b001 << owner_d) : 3'b000;
    end

    assign scan_tick = (scan_cnt_q == SW'(SCAN_DVSR - 1));

    always_comb begin
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
        dig_idx_d  = scan_tick ? dig_idx_q + 2'd1 : dig_idx_q;
    end

    // Display path follows the registered grant, so it lags by one cycle.
    always_comb begin
        own_seg = src2_seg;
        own_en  = src2_dig_en;
        if (grant_q[0]) begin
            own_seg = src0_seg;
            own_en  = src0_dig_en;
        end else if (grant_q[1]) begin
            own_seg = src1_seg;
            own_en  = src1_dig_en;
        end
        lit    = busy_q && disp_en && own_en[dig_idx_q];
        an_d   = lit ? ~(4'b0001 << dig_idx_q) : 4'hF;
        sseg_d = lit ? ~own_seg[8*dig_idx_q +: 8] : 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            rr_last_q  <= 2'd2;
            hold_cnt_q <= '0;
            scan_cnt_q <= '0;
            dig_idx_q  <= 2'd0;
            grant_q    <= 3'b000;
            busy_q     <= 1'b0;
            an_q       <= 4'hF;
            sseg_q     <= 8'hFF;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            hold_cnt_q <= hold_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign an    = an_q;
    assign sseg  = sseg_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: per-cycle reference model plus
// directed scenarios with hand-derived literal expectations.
module tb_seg_display_arbiter;
    localparam int SCAN = 4;
    localparam int HOLD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_en = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [31:0] s0 = 32'h3F06_5B4F;
    logic [31:0] s1 = 32'h7766_5544;
    logic [31:0] s2 = 32'h1122_3380;
    logic [3:0]  e0 = 4'hF;
    logic [3:0]  e1 = 4'hF;
    logic [3:0]  e2 = 4'hF;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int checks = 0;
    int failures = 0;

    seg_display_arbiter #(.SCAN_DVSR(SCAN), .HOLD_DVSR(HOLD)) dut (
        .clk(clk), .reset(reset), .disp_en(disp_en), .req(req),
        .src0_seg(s0), .src1_seg(s1), .src2_seg(s2),
        .src0_dig_en(e0), .src1_dig_en(e1), .src2_dig_en(e2),
        .grant(grant), .busy(busy), .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: owner as an integer, digit from elapsed cycles.
    int          m_own, m_last, m_hold, m_cyc;
    logic [3:0]  x_an;
    logic [7:0]  x_sseg;
    logic [2:0]  x_grant;

    function automatic int pick(int last, logic [2:0] r, bit excl);
        for (int k = 1; k <= 3; k++)
            if (!(excl && k == 3) && r[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    function automatic logic [31:0] seg_of(int i);
        return (i == 0) ? s0 : (i == 1) ? s1 : s2;
    endfunction

    function automatic logic [3:0] en_of(int i);
        return (i == 0) ? e0 : (i == 1) ? e1 : e2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_own = -1; m_last = 2; m_hold = 0; m_cyc = 0;
            x_an = 4'hF; x_sseg = 8'hFF; x_grant = 3'b000;
        end else begin
            int d, p;
            logic [3:0] en;
            logic [31:0] sg;
            d = (m_cyc / SCAN) % 4;
            x_an = 4'hF;
            x_sseg = 8'hFF;
            if (m_own >= 0) begin
                en = en_of(m_own);
                sg = seg_of(m_own);
                if (disp_en && en[d]) begin
                    x_an = ~(4'(1) << d);
                    x_sseg = ~sg[8*d +: 8];
                end
            end
            if (m_own < 0) begin
                p = pick(m_last, req, 1'b0);
                if (p >= 0) begin m_own = p; m_hold = 0; end
            end else begin
                p = pick(m_own, req, 1'b1);
                if (!req[m_own]) begin
                    if (p >= 0) m_own = p;
                    else begin m_last = m_own; m_own = -1; end
                    m_hold = 0;
                end else if (m_hold >= HOLD - 1 && p >= 0) begin
                    m_own = p; m_hold = 0;
                end else if (m_hold < HOLD - 1) m_hold++;
            end
            m_cyc++;
            x_grant = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_grant", {29'd0, grant}, {29'd0, x_grant});
            chk("model_busy", {31'd0, busy}, {31'd0, x_grant != 3'b000});
            chk("model_an", {28'd0, an}, {28'd0, x_an});
            chk("model_sseg", {24'd0, sseg}, {24'd0, x_sseg});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_sseg", {24'd0, sseg}, 32'hFF);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen_e, seen_b;
        // Scan order and segment inversion
        req = 3'b001;
        do_reset();
        tick(1); chk("t1_grant", {29'd0, grant}, 32'h1);
        tick(1); chk("t1_an0", {28'd0, an}, 32'hE);
        chk("t1_sg0", {24'd0, sseg}, 32'hB0);
        tick(4); chk("t1_an1", {28'd0, an}, 32'hD);
        chk("t1_sg1", {24'd0, sseg}, 32'hA4);
        tick(4); chk("t1_an2", {28'd0, an}, 32'hB);
        chk("t1_sg2", {24'd0, sseg}, 32'hF9);
        tick(4); chk("t1_an3", {28'd0, an}, 32'h7);
        chk("t1_sg3", {24'd0, sseg}, 32'hC0);

        // Waiting request must not cut the hold short
        req = 3'b001;
        do_reset();
        tick(3); req = 3'b011;
        tick(7); chk("t2_hold", {29'd0, grant}, 32'h1);
        tick(1); chk("t2_hand", {29'd0, grant}, 32'h2);

        // Full rotation
        req = 3'b111;
        do_reset();
        tick(1); chk("t3_g0", {29'd0, grant}, 32'h1);
        tick(10); chk("t3_g1", {29'd0, grant}, 32'h2);
        tick(10); chk("t3_g2", {29'd0, grant}, 32'h4);
        tick(10); chk("t3_g3", {29'd0, grant}, 32'h1);

        // Release paths
        req = 3'b101;
        do_reset();
        tick(4); req = 3'b100;
        tick(1); chk("t4_rel", {29'd0, grant}, 32'h4);
        req = 3'b001;
        do_reset();
        tick(2); chk("t4_lit", {28'd0, an}, 32'hE);
        req = 3'b000;
        tick(1); chk("t4_idle", {29'd0, grant}, 32'h0);
        chk("t4_busy", {31'd0, busy}, 32'h0);
        tick(1); chk("t4_blank", {28'd0, an}, 32'hF);

        // Partial digit enables and display disable
        req = 3'b001; e0 = 4'b0101;
        do_reset();
        seen_e = 0; seen_b = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (an == 4'hE) seen_e++;
            if (an == 4'hB) seen_b++;
            if (an != 4'hE && an != 4'hB && an != 4'hF)
                chk("t5_an_set", {28'd0, an}, 32'hF);
        end
        chk("t5_seen_e", {31'd0, seen_e > 0}, 32'h1);
        chk("t5_seen_b", {31'd0, seen_b > 0}, 32'h1);
        disp_en = 1'b0;
        tick(2); chk("t5_off_an", {28'd0, an}, 32'hF);
        chk("t5_off_sg", {24'd0, sseg}, 32'hFF);
        chk("t5_off_gr", {29'd0, grant}, 32'h1);
        disp_en = 1'b1; e0 = 4'hF;

        // Asynchronous reset mid-slot
        req = 3'b010;
        do_reset();
        tick(5); chk("t6_grant", {29'd0, grant}, 32'h2);
        #3 reset = 1'b1;
        #1 chk("t6_an", {28'd0, an}, 32'hF);
        chk("t6_sg", {24'd0, sseg}, 32'hFF);
        chk("t6_gr", {29'd0, grant}, 32'h0);
        do_reset();
        tick(1); chk("t6_regrant", {29'd0, grant}, 32'h2);
        tick(1); chk("t6_dig0", {28'd0, an}, 32'hE);
        chk("t6_sg0", {24'd0, sseg}, 32'hBB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
